// File: rtl/scan_address_generator_pkg.sv
// -----------------------------------------------------------------------------
// scan_address_generator_pkg
// Shared definitions for the scan address generator:
//   - scan_state_t     : frame FSM states (IDLE, SYNC, ACTIVE, DONE)
//   - DEF_IMG_W/H      : default active frame dimensions
//   - DEF_MAX_DEC      : default largest log2 decimation factor
//   - decimated_count  : number of kept pixels for a given decimation exponent
//   - kept_coord       : whether one coordinate survives decimation
// -----------------------------------------------------------------------------
package scan_address_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_t;

  localparam int DEF_IMG_W   = 320;
  localparam int DEF_IMG_H   = 240;
  localparam int DEF_MAX_DEC = 2;

  // Pixels written per frame when every 2^d-th column and row is kept.
  function automatic int decimated_count(input int img_w, input int img_h, input int d);
    return (img_w >> d) * (img_h >> d);
  endfunction

  // A coordinate is kept when its low d bits are zero and it does not fall in a
  // trailing partial block (which would push the address past its final value).
  function automatic logic kept_coord(input int coord, input int limit, input int d);
    return (((coord >> d) << d) == coord) && ((coord >> d) < (limit >> d));
  endfunction

endpackage

// File: rtl/scan_address_generator_xy_counter.sv
// -----------------------------------------------------------------------------
// scan_xy_counter
// Wrapping pixel/line counter for one camera frame.
// Ports:
//   clk25      in  : clock (rising edge)
//   rst        in  : synchronous active-high reset
//   clear      in  : synchronous return to x=0, y=0 (frame sync)
//   advance    in  : count one accepted pixel
//   x          out : pixel position in the line, 0..IMG_W-1
//   y          out : line position in the frame, 0..IMG_H-1
//   line_wrap  out : x is at the last pixel of the line
//   last_pixel out : x and y are at the last pixel of the frame
// -----------------------------------------------------------------------------
module scan_xy_counter
  import scan_address_generator_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  localparam int X_W  = $clog2(IMG_W),
  localparam int Y_W  = $clog2(IMG_H)
) (
  input  logic           clk25,
  input  logic           rst,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_wrap,
  output logic           last_pixel
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  logic [X_W-1:0] x_r;
  logic [Y_W-1:0] y_r;

  // Pixel and line counters; y wraps to 0 after the last line of the frame.
  always_ff @(posedge clk25) begin
    if (rst) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if (clear) begin
      x_r <= {X_W{1'b0}};
      y_r <= {Y_W{1'b0}};
    end else if (advance) begin
      if (line_wrap) begin
        x_r <= {X_W{1'b0}};
        y_r <= last_pixel ? {Y_W{1'b0}} : (y_r + Y_W'(1));
      end else begin
        x_r <= x_r + X_W'(1);
        y_r <= y_r;
      end
    end else begin
      x_r <= x_r;
      y_r <= y_r;
    end
  end

  assign x          = x_r;
  assign y          = y_r;
  assign line_wrap  = (x_r == X_LAST);
  assign last_pixel = line_wrap && (y_r == Y_LAST);

endmodule

// File: rtl/scan_address_generator.sv
// -----------------------------------------------------------------------------
// scan_address_generator
// Generates frame-buffer write addresses for a camera pixel stream, keeping
// only pixels on a 2^d grid (d = decimation exponent latched at frame sync).
// Ports:
//   clk25      in  : clock (rising edge)
//   rst        in  : synchronous active-high reset
//   enable     in  : one camera pixel per cycle high
//   vsync      in  : active-low frame sync
//   mode       in  : requested decimation exponent (clamped to MAX_DEC)
//   address    out : frame-buffer write address (holds between writes)
//   wr_en      out : write strobe qualifying address, one cycle after enable
//   frame_done out : high while the frame is complete
//   overrun    out : one-cycle pulse for a pixel arriving outside a frame
// -----------------------------------------------------------------------------
module scan_address_generator
  import scan_address_generator_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int MAX_DEC = DEF_MAX_DEC,
  localparam int ADDR_W = $clog2(IMG_W * IMG_H),
  localparam int MODE_W = $clog2(MAX_DEC + 1)
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              enable,
  input  logic              vsync,
  input  logic [MODE_W-1:0] mode,
  output logic [ADDR_W-1:0] address,
  output logic              wr_en,
  output logic              frame_done,
  output logic              overrun
);

  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);
  localparam logic [MODE_W-1:0] MAX_D = MODE_W'(MAX_DEC);

  scan_state_t state_r;
  scan_state_t state_next_s;

  logic [MODE_W-1:0] d_r;
  logic [MODE_W-1:0] d_clamp_s;
  logic [ADDR_W-1:0] wr_count_r;
  logic [ADDR_W-1:0] address_r;
  logic              wr_en_r;
  logic              frame_done_r;
  logic              overrun_r;
  logic              row_keep_r;

  logic [X_W-1:0]    x_s;
  logic [Y_W-1:0]    y_s;
  logic              line_wrap_s;
  logic              last_pixel_s;
  logic              advance_s;
  logic              clear_s;

  logic              keep_s;
  logic              row_keep_next_s;
  logic              wr_en_next_s;
  logic              overrun_next_s;
  logic              frame_done_next_s;

  // Frame sync clears the counters; pixels count only inside an active frame.
  assign clear_s   = !vsync;
  assign advance_s = (state_r == ST_ACTIVE) && vsync && enable;
  assign d_clamp_s = (mode > MAX_D) ? MAX_D : mode;

  scan_xy_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_xy (
    .clk25      (clk25),
    .rst        (rst),
    .clear      (clear_s),
    .advance    (advance_s),
    .x          (x_s),
    .y          (y_s),
    .line_wrap  (line_wrap_s),
    .last_pixel (last_pixel_s)
  );

  // State register.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a low vsync restarts the frame from any state.
  always_comb begin
    state_next_s = state_r;
    if (!vsync) begin
      state_next_s = ST_SYNC;
    end else begin
      case (state_r)
        ST_IDLE:   state_next_s = ST_IDLE;
        ST_SYNC:   state_next_s = ST_ACTIVE;
        ST_ACTIVE: begin
          if (advance_s && last_pixel_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ACTIVE;
          end
        end
        ST_DONE:   state_next_s = ST_DONE;
        default:   state_next_s = ST_IDLE;
      endcase
    end
  end

  // Output decode: decimation qualifier, overrun detect and done flag.
  // The row test is precomputed at each line wrap so only x is tested per pixel.
  always_comb begin
    keep_s            = advance_s && row_keep_r &&
                        kept_coord(int'(x_s), IMG_W, int'(d_r));
    wr_en_next_s      = keep_s;
    overrun_next_s    = vsync && enable &&
                        ((state_r == ST_IDLE) || (state_r == ST_DONE));
    frame_done_next_s = (state_next_s == ST_DONE);
    row_keep_next_s   = row_keep_r;
    if (!vsync) begin
      row_keep_next_s = 1'b1;
    end else if (advance_s && line_wrap_s) begin
      if (last_pixel_s) begin
        row_keep_next_s = 1'b1;
      end else begin
        row_keep_next_s = kept_coord(int'(y_s) + 1, IMG_H, int'(d_r));
      end
    end else begin
      row_keep_next_s = row_keep_r;
    end
  end

  // Decimation latch, row qualifier, address counter and registered outputs.
  always_ff @(posedge clk25) begin
    if (rst) begin
      d_r          <= {MODE_W{1'b0}};
      row_keep_r   <= 1'b1;
      wr_count_r   <= {ADDR_W{1'b0}};
      address_r    <= {ADDR_W{1'b0}};
      wr_en_r      <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      row_keep_r   <= row_keep_next_s;
      wr_en_r      <= wr_en_next_s;
      frame_done_r <= frame_done_next_s;
      overrun_r    <= overrun_next_s;
      if (!vsync) begin
        d_r        <= d_clamp_s;
        wr_count_r <= {ADDR_W{1'b0}};
        address_r  <= {ADDR_W{1'b0}};
      end else if (keep_s) begin
        d_r        <= d_r;
        address_r  <= wr_count_r;
        wr_count_r <= wr_count_r + ADDR_W'(1);
      end else begin
        d_r        <= d_r;
        address_r  <= address_r;
        wr_count_r <= wr_count_r;
      end
    end
  end

  assign address    = address_r;
  assign wr_en      = wr_en_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_scan_address_generator.sv
// -----------------------------------------------------------------------------
// tb_scan_address_generator
// Self-checking bench. The DUT runs with a reduced 32x24 frame so that several
// complete frames fit in a short run; the expected frame-level numbers are
// derived from TW/TH below rather than the 320x240 defaults.
// -----------------------------------------------------------------------------
module tb_scan_address_generator;

  localparam int TW   = 32;
  localparam int TH   = 24;
  localparam int MAXD = 2;
  localparam int AW   = $clog2(TW * TH);

  logic          clk25 = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          vsync = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] address;
  logic          wr_en;
  logic          frame_done;
  logic          overrun;

  always #5 clk25 = ~clk25;

  scan_address_generator #(
    .IMG_W   (TW),
    .IMG_H   (TH),
    .MAX_DEC (MAXD)
  ) dut (
    .clk25      (clk25),
    .rst        (rst),
    .enable     (enable),
    .vsync      (vsync),
    .mode       (mode),
    .address    (address),
    .wr_en      (wr_en),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0=idle 1=sync 2=active 3=done, p = pixels accepted.
  int m_ph = 0;
  int m_p = 0;
  int m_d = 0;
  int m_addr = 0;
  int m_wr = 0;
  int m_ovr = 0;

  int wr_seen = 0;
  int last_addr = -1;

  typedef struct {
    logic r;
    logic v;
    logic e;
    logic [1:0] m;
    int ew;
    int eo;
    int ed;
    int ea;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected behaviour from the frame rules: pixel p sits at x=p%W, y=p/W and is
  // written at its position in the decimated image.
  task automatic model_step(input logic r, input logic v, input logic e, input logic [1:0] m);
    int x;
    int y;
    int s;
    m_wr  = 0;
    m_ovr = 0;
    if (r) begin
      m_ph = 0; m_p = 0; m_d = 0; m_addr = 0;
    end else if (!v) begin
      m_ph = 1; m_p = 0; m_addr = 0;
      m_d  = (int'(m) > MAXD) ? MAXD : int'(m);
    end else if (m_ph == 0 || m_ph == 3) begin
      m_ovr = e ? 1 : 0;
    end else if (m_ph == 1) begin
      m_ph = 2;
    end else if (e) begin
      x = m_p % TW;
      y = m_p / TW;
      s = 1 << m_d;
      if (x % s == 0 && y % s == 0 && x / s < TW / s && y / s < TH / s) begin
        m_wr   = 1;
        m_addr = (y / s) * (TW / s) + x / s;
      end
      m_p++;
      if (m_p == TW * TH) m_ph = 3;
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic e, input logic [1:0] m);
    rst = r; vsync = v; enable = e; mode = m;
    @(posedge clk25);
    model_step(r, v, e, m);
    #1;
    check("wr_en", int'(wr_en), m_wr);
    check("overrun", int'(overrun), m_ovr);
    check("frame_done", int'(frame_done), (m_ph == 3) ? 1 : 0);
    check("address", int'(address), m_addr);
    check("wr_ovr_excl", int'(wr_en && overrun), 0);
    if (wr_en) begin
      wr_seen++;
      last_addr = int'(address);
    end
  endtask

  task automatic start_frame(input logic [1:0] m);
    cycle(1'b0, 1'b0, 1'b0, m);
    cycle(1'b0, 1'b1, 1'b0, m);
    wr_seen   = 0;
    last_addr = -1;
  endtask

  task automatic run_pixels(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, m);
  endtask

  initial begin
    // {rst, vsync, enable, mode, wr_en, overrun, frame_done, address}
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'd0, 0, 1, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 0, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd1, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 2'd1, 1, 0, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'd1, 0, 0, 0, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 2'd1, 1, 0, 0, 1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'd0, 0, 0, 0, 1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1, 0, 0, 2};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd0, 0, 0, 0, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 2'd0, 0, 0, 0, 0};

    cycle(1'b1, 1'b1, 1'b0, 2'd0);
    cycle(1'b1, 1'b1, 1'b0, 2'd0);

    // Table of short hand-computed vectors.
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].e, tbl[i].m);
      check($sformatf("tbl%0d_wr", i), int'(wr_en), tbl[i].ew);
      check($sformatf("tbl%0d_ovr", i), int'(overrun), tbl[i].eo);
      check($sformatf("tbl%0d_done", i), int'(frame_done), tbl[i].ed);
      check($sformatf("tbl%0d_addr", i), int'(address), tbl[i].ea);
    end

    // Full frame, no decimation, then a pixel arriving after completion.
    start_frame(2'd0);
    run_pixels(TW * TH, 2'd0);
    check("full_count", wr_seen, TW * TH);
    check("full_last", last_addr, TW * TH - 1);
    cycle(1'b0, 1'b1, 1'b0, 2'd0);
    check("full_done", int'(frame_done), 1);
    cycle(1'b0, 1'b1, 1'b1, 2'd0);
    check("done_ovr", int'(overrun), 1);
    check("done_hold", int'(address), TW * TH - 1);
    check("done_wr", int'(wr_en), 0);
    cycle(1'b0, 1'b1, 1'b0, 2'd0);
    check("done_ovr_end", int'(overrun), 0);

    // Decimate by 2: check the write at (0,0) and at (0,2).
    start_frame(2'd1);
    for (int p = 0; p < TW * TH; p++) begin
      cycle(1'b0, 1'b1, 1'b1, 2'd1);
      if (p == 0) begin
        check("d1_first_wr", int'(wr_en), 1);
        check("d1_first_addr", int'(address), 0);
      end
      if (p == 2 * TW) begin
        check("d1_row2_wr", int'(wr_en), 1);
        check("d1_row2_addr", int'(address), TW / 2);
      end
    end
    check("d1_count", wr_seen, (TW / 2) * (TH / 2));
    check("d1_last", last_addr, (TW / 2) * (TH / 2) - 1);

    // Requested mode above MAX_DEC is clamped.
    start_frame(2'd3);
    run_pixels(TW * TH, 2'd3);
    check("clamp_count", wr_seen, (TW / 4) * (TH / 4));
    check("clamp_last", last_addr, (TW / 4) * (TH / 4) - 1);

    // vsync low coincident with a pixel that would have written address 100.
    start_frame(2'd0);
    run_pixels(100, 2'd0);
    check("vs_pre_addr", int'(address), 99);
    cycle(1'b0, 1'b0, 1'b1, 2'd0);
    check("vs_wr", int'(wr_en), 0);
    check("vs_addr", int'(address), 0);
    cycle(1'b0, 1'b1, 1'b0, 2'd0);
    cycle(1'b0, 1'b1, 1'b1, 2'd0);
    check("vs_next_wr", int'(wr_en), 1);
    check("vs_next_addr", int'(address), 0);

    // Reset mid-frame, then pixels without a frame sync.
    start_frame(2'd0);
    run_pixels(50, 2'd0);
    cycle(1'b1, 1'b1, 1'b1, 2'd0);
    check("rst_wr", int'(wr_en), 0);
    check("rst_addr", int'(address), 0);
    wr_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 2'd0);
      check("rst_ovr", int'(overrun), 1);
    end
    check("rst_no_wr", wr_seen, 0);
    start_frame(2'd0);
    run_pixels(5, 2'd0);
    check("rst_resume_count", wr_seen, 5);
    check("rst_resume_last", last_addr, 4);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      logic r;
      logic v;
      logic e;
      logic [1:0] m;
      r = ($urandom_range(0, 1999) == 0);
      v = ($urandom_range(0, 799) != 0);
      e = ($urandom_range(0, 9) < 8);
      m = 2'($urandom_range(0, 3));
      cycle(r, v, e, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
